xgmm_wr: RTL and testbench

Memory-side consumer for the graphics register interface FIFOs. Drains full pattern (16-word) and attribute (4-word) bursts from the two queues and issues single-word writes to the shared video memory port through a req/ack handshake. Addresses come from the pattern and attribute address registers maintained by the register interface. Sits between the register interface FIFOs and the SDRAM arbiter.

---
 rtl/xgmm_wr.sv | 162 ++++++++++++++++
 tb/tb_xgmm_wr.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmm_wr.sv
// xgmm_wr: drains full pattern (16-word) and attribute (4-word) bursts from the
// register-interface queues into single-word writes on the shared video memory port.
module xgmm_wr (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        p_full,
  input  logic        p_empty,
  input  logic [15:0] p_data,
  output logic        p_pop,
  input  logic        a_full,
  input  logic        a_empty,
  input  logic [15:0] a_data,
  output logic        a_pop,
  input  logic [11:0] par,
  input  logic [12:0] aar,
  output logic        mem_req,
  output logic        mem_sel,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    P_REQ,
    P_POP,
    A_REQ,
    A_POP
  } state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n, idx_inc;
  logic [11:0] base_par, base_par_n;
  logic [10:0] base_aar, base_aar_n;
  logic        last_attr, last_attr_n;  // 1: attribute queue was granted last
  logic        req_q, req_n;
  logic        sel_n;
  logic [15:0] addr_n;
  logic        p_pop_n, a_pop_n;
  logic        sel_empty;
  logic        unused_aar_lsb;

  assign unused_aar_lsb = ^aar[1:0];
  assign idx_inc        = idx + 4'd1;
  assign sel_empty      = mem_sel ? a_empty : p_empty;

  // An empty queue under an open request is an underrun: never show it to memory.
  assign mem_req   = req_q & ~sel_empty;
  assign mem_wdata = mem_sel ? a_data : p_data;
  assign busy      = (state != IDLE);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    base_par_n  = base_par;
    base_aar_n  = base_aar;
    last_attr_n = last_attr;
    req_n       = 1'b0;
    sel_n       = mem_sel;
    addr_n      = mem_addr;
    p_pop_n     = 1'b0;
    a_pop_n     = 1'b0;

    case (state)
      IDLE: begin
        if (p_full && (!a_full || last_attr)) begin
          state_n    = P_REQ;
          base_par_n = par;
          idx_n      = 4'd0;
          req_n      = 1'b1;
          sel_n      = 1'b0;
          addr_n     = {par, 4'h0};
        end else if (a_full) begin
          state_n    = A_REQ;
          base_aar_n = aar[12:2];
          idx_n      = 4'd0;
          req_n      = 1'b1;
          sel_n      = 1'b1;
          addr_n     = {3'b000, aar[12:2], 2'b00};
        end
      end

      P_REQ: begin
        if (p_empty) begin
          state_n = IDLE;
        end else if (mem_ack) begin
          state_n = P_POP;
          p_pop_n = 1'b1;
        end else begin
          req_n = 1'b1;
        end
      end

      P_POP: begin
        if (idx == 4'd15) begin
          state_n     = IDLE;
          last_attr_n = 1'b0;
        end else begin
          state_n = P_REQ;
          idx_n   = idx_inc;
          req_n   = 1'b1;
          addr_n  = {base_par, idx_inc};
        end
      end

      A_REQ: begin
        if (a_empty) begin
          state_n = IDLE;
        end else if (mem_ack) begin
          state_n = A_POP;
          a_pop_n = 1'b1;
        end else begin
          req_n = 1'b1;
        end
      end

      A_POP: begin
        if (idx[1:0] == 2'd3) begin
          state_n     = IDLE;
          last_attr_n = 1'b1;
        end else begin
          state_n = A_REQ;
          idx_n   = idx_inc;
          req_n   = 1'b1;
          addr_n  = {3'b000, base_aar, idx_inc[1:0]};
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      base_par  <= 12'd0;
      base_aar  <= 11'd0;
      last_attr <= 1'b1;
      req_q     <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= 16'd0;
      p_pop     <= 1'b0;
      a_pop     <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      base_par  <= base_par_n;
      base_aar  <= base_aar_n;
      last_attr <= last_attr_n;
      req_q     <= req_n;
      mem_sel   <= sel_n;
      mem_addr  <= addr_n;
      p_pop     <= p_pop_n;
      a_pop     <= a_pop_n;
    end
  end

endmodule

// File: tb/tb_xgmm_wr.sv
// Directed bench for xgmm_wr: FWFT queue models feed the DUT and a scripted
// memory responder acknowledges each request; expected words come from fill tables.
module tb_xgmm_wr;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        p_full  = 1'b0;
  logic        p_empty = 1'b1;
  logic [15:0] p_data  = 16'h0;
  logic        p_pop;
  logic        a_full  = 1'b0;
  logic        a_empty = 1'b1;
  logic [15:0] a_data  = 16'h0;
  logic        a_pop;
  logic [11:0] par     = 12'h0;
  logic [12:0] aar     = 13'h0;
  logic        mem_req;
  logic        mem_sel;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] pq[$];
  logic [15:0] aq[$];
  logic [15:0] pp_in[$];
  logic [15:0] ap_in[$];
  logic [15:0] exp_d [0:15];

  xgmm_wr dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .p_full   (p_full),
    .p_empty  (p_empty),
    .p_data   (p_data),
    .p_pop    (p_pop),
    .a_full   (a_full),
    .a_empty  (a_empty),
    .a_data   (a_data),
    .a_pop    (a_pop),
    .par      (par),
    .aar      (aar),
    .mem_req  (mem_req),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Queue models update on the falling edge, so the DUT samples settled flags.
  always @(negedge clk_sys) begin
    if (p_pop && pq.size() > 0) void'(pq.pop_front());
    if (a_pop && aq.size() > 0) void'(aq.pop_front());
    while (pp_in.size() > 0 && pq.size() < 16) pq.push_back(pp_in.pop_front());
    while (ap_in.size() > 0 && aq.size() < 4) aq.push_back(ap_in.pop_front());
    p_full  = (pq.size() == 16);
    p_empty = (pq.size() == 0);
    p_data  = (pq.size() > 0) ? pq[0] : 16'h0;
    a_full  = (aq.size() == 4);
    a_empty = (aq.size() == 0);
    a_data  = (aq.size() > 0) ? aq[0] : 16'h0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic fill_p(input logic [15:0] d0, input int n);
    #1;
    for (int i = 0; i < n; i++) pp_in.push_back(d0 + 16'(i));
  endtask

  task automatic fill_a(input logic [15:0] d0, input int n);
    #1;
    for (int i = 0; i < n; i++) ap_in.push_back(d0 + 16'(i));
  endtask

  task automatic set_exp(input logic [15:0] d0);
    for (int i = 0; i < 16; i++) exp_d[i] = d0 + 16'(i);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
  endtask

  // Serves n words of one burst: checks each request, optionally stalls the ack
  // on word stall_w, and rewrites par when word chg_w comes up.
  task automatic run_burst(input bit attr, input logic [15:0] addr0, input int n,
                           input int stall_w, input int chg_w, input bit final_chk);
    for (int w = 0; w < n; w++) begin
      int t;
      if (w == chg_w) par = 12'h7FF;
      t = 0;
      while (mem_req !== 1'b1 && t < 40) begin
        @(negedge clk_sys);
        t++;
      end
      total++;
      if (mem_req !== 1'b1) begin
        bad++;
        $display("FAIL req_timeout: word %0d got no mem_req within 40 cycles", w);
        return;
      end
      total++;
      if (mem_sel !== attr || mem_addr !== addr0 + 16'(w) || mem_wdata !== exp_d[w]) begin
        bad++;
        $display("FAIL word: w=%0d got sel=%0b addr=%h data=%h want sel=%0b addr=%h data=%h",
                 w, mem_sel, mem_addr, mem_wdata, attr, addr0 + 16'(w), exp_d[w]);
      end
      if (w == stall_w) begin
        repeat (10) begin
          @(negedge clk_sys);
          total++;
          if (mem_req !== 1'b1 || mem_addr !== addr0 + 16'(w) || mem_wdata !== exp_d[w] ||
              p_pop !== 1'b0 || a_pop !== 1'b0) begin
            bad++;
            $display("FAIL stall: got req=%0b addr=%h data=%h pops=%0b%0b want req=1 addr=%h data=%h pops=00",
                     mem_req, mem_addr, mem_wdata, p_pop, a_pop, addr0 + 16'(w), exp_d[w]);
          end
        end
      end
      mem_ack = 1'b1;
      @(negedge clk_sys);
      mem_ack = 1'b0;
      total++;
      if ((attr ? a_pop : p_pop) !== 1'b1 || (attr ? p_pop : a_pop) !== 1'b0 || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL pop: w=%0d got p_pop=%0b a_pop=%0b req=%0b want own pop=1 other=0 req=0",
                 w, p_pop, a_pop, mem_req);
      end
    end
    if (final_chk) begin
      @(negedge clk_sys);
      total++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL end_idle: got busy=%0b req=%0b want 0 0", busy, mem_req);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    total++;
    if ({mem_req, mem_sel, mem_addr, p_pop, a_pop, busy} !== 21'd0) begin
      bad++;
      $display("FAIL reset_vals: got req=%0b sel=%0b addr=%h p_pop=%0b a_pop=%0b busy=%0b want all 0",
               mem_req, mem_sel, mem_addr, p_pop, a_pop, busy);
    end
    rst_n = 1'b1;
    @(negedge clk_sys);
    mem_ack = 1'b1;
    @(negedge clk_sys);
    mem_ack = 1'b0;
    @(negedge clk_sys);
    total++;
    if ({mem_req, p_pop, a_pop, busy} !== 4'd0) begin
      bad++;
      $display("FAIL idle_ack: got req=%0b p_pop=%0b a_pop=%0b busy=%0b want all 0",
               mem_req, p_pop, a_pop, busy);
    end
  endtask

  task automatic test_pattern();
    par = 12'h123;
    set_exp(16'h1000);
    fill_p(16'h1000, 15);
    repeat (5) @(negedge clk_sys);
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL partial: got req=%0b busy=%0b want 0 0 with 15 words queued", mem_req, busy);
    end
    #1;
    pp_in.push_back(16'h100F);
    @(negedge clk_sys);
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL start_early: got req=%0b want 0 before full is sampled", mem_req);
    end
    @(negedge clk_sys);
    total++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_latency: got req=%0b busy=%0b want 1 1", mem_req, busy);
    end
    run_burst(1'b0, 16'h1230, 16, -1, -1, 1'b1);
    total++;
    if (pq.size() != 0) begin
      bad++;
      $display("FAIL p_drain: got %0d words left want 0", pq.size());
    end
  endtask

  task automatic test_attr();
    aar = 13'h00A5;
    set_exp(16'h00A0);
    fill_a(16'h00A0, 4);
    run_burst(1'b1, 16'h00A4, 4, -1, -1, 1'b1);
  endtask

  task automatic test_tie();
    apply_reset();
    par = 12'h100;
    aar = 13'h0040;
    repeat (2) begin
      fill_p(16'h4000, 16);
      fill_a(16'h0050, 4);
      set_exp(16'h4000);
      run_burst(1'b0, 16'h1000, 16, -1, -1, 1'b1);
      set_exp(16'h0050);
      run_burst(1'b1, 16'h0040, 4, -1, -1, 1'b1);
    end
    fill_p(16'h4100, 16);
    set_exp(16'h4100);
    run_burst(1'b0, 16'h1000, 16, -1, -1, 1'b1);
    fill_p(16'h4200, 16);
    fill_a(16'h0060, 4);
    set_exp(16'h0060);
    run_burst(1'b1, 16'h0040, 4, -1, -1, 1'b1);
    set_exp(16'h4200);
    run_burst(1'b0, 16'h1000, 16, -1, -1, 1'b1);
  endtask

  task automatic test_stall();
    par = 12'h222;
    set_exp(16'h6000);
    fill_p(16'h6000, 16);
    run_burst(1'b0, 16'h2220, 16, 5, -1, 1'b1);
  endtask

  task automatic test_par_change();
    par = 12'h345;
    set_exp(16'h7000);
    fill_p(16'h7000, 16);
    run_burst(1'b0, 16'h3450, 16, -1, 8, 1'b1);
    set_exp(16'h7100);
    fill_p(16'h7100, 16);
    run_burst(1'b0, 16'h7FF0, 16, -1, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    int t;
    par = 12'h010;
    set_exp(16'h2000);
    fill_p(16'h2000, 16);
    run_burst(1'b0, 16'h0100, 7, -1, -1, 1'b0);
    t = 0;
    while (mem_req !== 1'b1 && t < 40) begin
      @(negedge clk_sys);
      t++;
    end
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0107) begin
      bad++;
      $display("FAIL word7_req: got req=%0b addr=%h want 1 0107", mem_req, mem_addr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_req, p_pop, busy, mem_sel, mem_addr} !== 20'd0) begin
      bad++;
      $display("FAIL async_reset: got req=%0b p_pop=%0b busy=%0b sel=%0b addr=%h want all 0",
               mem_req, p_pop, busy, mem_sel, mem_addr);
    end
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || pq.size() != 9) begin
      bad++;
      $display("FAIL post_reset_idle: got req=%0b busy=%0b queued=%0d want 0 0 9",
               mem_req, busy, pq.size());
    end
    for (int i = 0; i < 9; i++) exp_d[i] = 16'h2007 + 16'(i);
    for (int i = 9; i < 16; i++) exp_d[i] = 16'h3000 + 16'(i - 9);
    fill_p(16'h3000, 7);
    run_burst(1'b0, 16'h0100, 16, -1, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_attr();
    test_tie();
    test_stall();
    test_par_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
